jt49_eg_sched: RTL and testbench
================================

Name: jt49_eg_sched

Overview:
Controller that configures and paces the envelope generator (EG).
- Holds the three envelope CPU registers: period fine, period coarse, shape.
- Runs the envelope period prescaler and counter.
- Drives the EG control inputs: step, null_period, restart, ctrl.
- Sits between the register-bank decode and the EG; all EG timing derives from cen.

Parameters:
PRESC, 2, cen pulses per period-counter tick; must be >=2 (elaboration-time check fails otherwise).
PW, 16, period width in bits; fine = low 8, coarse = high PW-8.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  clock enable; all EG-facing timing advances only on cen
wr  in  1  register write strobe, one clk wide, not cen-qualified
addr  in  2  0=fine, 1=coarse, 2=shape, 3=unused
din  in  8  write data
dout  out  8  combinational readback of addressed register; 0 for addr 3
step  out  1  to EG; one rising edge per envelope period
null_period  out  1  to EG; high while period register is zero
restart  out  1  to EG; restart request
ctrl  out  4  to EG; shape[3:0] (CONT, ATT, ALT, HOLD)

Behaviour:
- Reset (async): fine=0, coarse=0, shape=0, prescaler=0, counter=0, step=0, restart=0, null_period=1, ctrl=0.
- Writes are decoded on any clk edge, independent of cen.
  - Registers update on the next edge.
  - addr 3 writes are ignored.
  - Coarse stores only din[PW-9:0].
- period = {coarse, fine}. null_period is registered: it equals (period==0) one clk after any write.
- Prescaler:
  - On cen, pre increments and wraps at PRESC-1.
  - The wrap cycle is a tick.
- Counter, on tick:
  - If cnt >= period-1: cnt <= 0 and the expiry flag is set.
  - Otherwise cnt <= cnt+1.
  - The >= compare means a period shrunk below cnt expires on the very next tick, with no wrap through 2^PW.
- step:
  - Registered and updated only on cen.
  - step <= 1 on the cen edge following an expiry tick; step <= 0 on the next cen edge.
  - Result: exactly one rising edge per period*PRESC cen pulses, high for one cen interval.
  - PRESC>=2 guarantees step is low again before the next expiry.
- null_period=1:
  - Counter and prescaler are held at 0 and step is forced 0.
  - The EG advances itself via null_period.
- Period writes (addr 0/1) do not reset the counter or prescaler.
- Shape write (addr 2):
  - ctrl updates on the next clk.
  - restart <= 1 on the next clk edge.
  - Prescaler, counter and step are cleared on that same edge.
- restart clear rule: restart stays high until the first cen-qualified edge at which it was already 1, and is cleared at that edge. The EG therefore sees exactly one cen cycle with restart=1.
- Simultaneous shape write and cen on the same edge:
  - The write wins; restart becomes/remains 1.
  - Counting restarts from 0.
  - restart clears at the following cen.
- Two shape writes before any cen: a single restart, with ctrl holding the latest value.
- No counter tick occurs while restart=1 (pre and cnt are held at 0).
- Reset mid-operation: every output returns to its reset value immediately; no pending restart survives.

Decomposition:
Shared package jt49_eg_pkg holds:
- address constants ADDR_FINE=0, ADDR_COARSE=1, ADDR_SHAPE=2;
- default PRESC and PW;
- bit-position constants for CONT/ATT/ALT/HOLD.

One sub-module, jt49_eg_period:
- Contains the prescaler, counter, expiry and step logic.
- Inputs: clk, rst_n, cen, period, clr.
- Outputs: step, tick (debug).
- The top level keeps the register file, readback mux, null_period and the restart handshake.

Test Plan:
- Reset release, no writes, cen every clk -> null_period=1, step=0, restart=0, ctrl=0, dout=0 on all addresses.
- Write fine=3, coarse=0, cen every clk, PRESC=2 -> null_period falls one clk after the write; step rising edges exactly 6 cen apart, each high for 1 cen.
- Write shape=4'hE between cens (cen every 4th clk) -> ctrl=E next clk; restart high until the next cen edge, then low; first step edge 6 cen later (period 3).
- Period 100 running, cnt≈50, write fine=10 -> step edge on the next tick after the write, then every 20 cen.
- Shape write on the same edge as cen, then a second shape write before the next cen -> exactly one cen-sampled restart pulse; ctrl equals the second value.
- Assert rst_n low while restart=1 and step=1 -> both drop immediately; all registers 0; null_period=1.

Source files
------------

// File: rtl/jt49_eg_pkg.sv
// Shared constants for the envelope scheduler: register addresses, default
// sizing and the bit layout of the shape register as seen by the EG.
package jt49_eg_pkg;

    localparam logic [1:0] ADDR_FINE   = 2'd0;
    localparam logic [1:0] ADDR_COARSE = 2'd1;
    localparam logic [1:0] ADDR_SHAPE  = 2'd2;

    localparam int unsigned PRESC_DEF = 2;
    localparam int unsigned PW_DEF    = 16;

    localparam int unsigned CONT_BIT = 3;
    localparam int unsigned ATT_BIT  = 2;
    localparam int unsigned ALT_BIT  = 1;
    localparam int unsigned HOLD_BIT = 0;

endpackage

// File: rtl/jt49_eg_period.sv
// Envelope period pacing: cen prescaler, period counter and the one-cen-wide
// step pulse that follows every counter expiry.
module jt49_eg_period
    import jt49_eg_pkg::*;
#(
    parameter int unsigned PRESC = PRESC_DEF,
    parameter int unsigned PW    = PW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [PW-1:0] period,
    input  logic          clr,
    output logic          step,
    output logic          tick
);

    localparam int unsigned PRW = (PRESC > 1) ? $clog2(PRESC) : 1;

    logic [PRW-1:0] pre_q, pre_d;
    logic [PW-1:0]  cnt_q, cnt_d;
    logic           exp_q, exp_d;
    logic           step_q, step_d;
    logic           pre_wrap;

    always_comb begin
        pre_wrap = (pre_q == PRW'(PRESC - 1));
        tick     = cen && pre_wrap && !clr;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        exp_d    = exp_q;
        step_d   = step_q;
        if (clr) begin
            pre_d  = '0;
            cnt_d  = '0;
            exp_d  = 1'b0;
            step_d = 1'b0;
        end else if (cen) begin
            pre_d  = pre_wrap ? '0 : pre_q + PRW'(1);
            step_d = exp_q;
            exp_d  = 1'b0;
            if (pre_wrap) begin
                // >= so a period shrunk below cnt expires now instead of wrapping
                if (cnt_q >= period - PW'(1)) begin
                    cnt_d = '0;
                    exp_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            exp_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            exp_q  <= exp_d;
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/jt49_eg_sched.sv
// Envelope generator controller: CPU-visible period/shape registers, readback,
// null-period detection and the cen-synchronised restart handshake.
module jt49_eg_sched
    import jt49_eg_pkg::*;
#(
    parameter int unsigned PRESC = PRESC_DEF,
    parameter int unsigned PW    = PW_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       wr,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       step,
    output logic       null_period,
    output logic       restart,
    output logic [3:0] ctrl
);

    localparam int unsigned CW = PW - 8;

    if (PRESC < 2) begin : g_presc_chk
        $error("jt49_eg_sched: PRESC must be >= 2");
    end
    if (PW < 9 || PW > 16) begin : g_pw_chk
        $error("jt49_eg_sched: PW must be within 9..16");
    end

    logic [7:0]    fine_q, fine_d;
    logic [CW-1:0] coarse_q, coarse_d;
    logic [3:0]    shape_q, shape_d;
    logic          null_q, null_d;
    logic          restart_q, restart_d;
    logic          shape_wr;
    logic          clr;
    logic          tick;
    logic [PW-1:0] period;

    always_comb begin
        fine_d   = fine_q;
        coarse_d = coarse_q;
        shape_d  = shape_q;
        shape_wr = 1'b0;
        if (wr) begin
            case (addr)
                ADDR_FINE:   fine_d   = din;
                ADDR_COARSE: coarse_d = din[CW-1:0];
                ADDR_SHAPE: begin
                    shape_d  = din[3:0];
                    shape_wr = 1'b1;
                end
                default: ;
            endcase
        end

        period = {coarse_q, fine_q};
        null_d = (period == '0);

        // A write on the same edge as the clearing cen wins, re-arming restart
        restart_d = restart_q;
        if (cen && restart_q) restart_d = 1'b0;
        if (shape_wr)         restart_d = 1'b1;

        clr = null_q | shape_wr;

        dout = '0;
        case (addr)
            ADDR_FINE:   dout = fine_q;
            ADDR_COARSE: dout = 8'(coarse_q);
            ADDR_SHAPE:  dout = {4'b0000, shape_q};
            default:     dout = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fine_q    <= '0;
            coarse_q  <= '0;
            shape_q   <= '0;
            null_q    <= 1'b1;
            restart_q <= 1'b0;
        end else begin
            fine_q    <= fine_d;
            coarse_q  <= coarse_d;
            shape_q   <= shape_d;
            null_q    <= null_d;
            restart_q <= restart_d;
        end
    end

    jt49_eg_period #(
        .PRESC (PRESC),
        .PW    (PW)
    ) u_period (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen    (cen),
        .period (period),
        .clr    (clr),
        .step   (step),
        .tick   (tick)
    );

    // Counting must be frozen whenever restart is pending or the period is null
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(tick && (restart_q || null_q)));
    end

    assign null_period = null_q;
    assign restart     = restart_q;
    assign ctrl        = {shape_q[CONT_BIT], shape_q[ATT_BIT], shape_q[ALT_BIT], shape_q[HOLD_BIT]};

endmodule

// File: tb/tb_jt49_eg_sched.sv
// Self-checking bench for jt49_eg_sched: register table, step pacing via a
// scoreboard of expected cen indices, restart handshake and async reset.
module tb_jt49_eg_sched;
    import jt49_eg_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen   = 1'b0;
    logic       wr    = 1'b0;
    logic [1:0] addr  = '0;
    logic [7:0] din   = '0;
    logic [7:0] dout;
    logic       step, null_period, restart;
    logic [3:0] ctrl;

    int unsigned n_chk = 0, n_fail = 0;
    int unsigned ncen = 0, rise_cen = 0, n_rst_samp = 0, base = 0;
    logic        step_prev = 1'b0;
    int unsigned sb[$];

    typedef struct {
        logic [1:0] addr;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_null;
    } vec_t;
    vec_t tv[8];

    always #5 clk = ~clk;

    jt49_eg_sched #(.PRESC(2), .PW(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cen         (cen),
        .wr          (wr),
        .addr        (addr),
        .din         (din),
        .dout        (dout),
        .step        (step),
        .null_period (null_period),
        .restart     (restart),
        .ctrl        (ctrl)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clk: drive at negedge, sample 1 time unit after the rising edge
    task automatic cyc(input logic c, input logic w, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cen = c; wr = w; addr = a; din = d;
        if (c && restart) n_rst_samp++;
        @(posedge clk);
        #1;
        if (c) ncen++;
        if (step && !step_prev) begin
            rise_cen = ncen;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL step_unexpected: rise at cen %0d, none expected", ncen);
            end else begin
                chk("step_rise_cen", ncen, sb.pop_front());
            end
        end
        if (!step && step_prev && !(w && a == ADDR_SHAPE))
            chk("step_width", ncen - rise_cen, 1);
        step_prev = step;
    endtask

    task automatic run_until(input int unsigned target);
        for (int i = 0; i < 1000 && ncen < target; i++) cyc(1'b1, 1'b0, 2'd0, 8'd0);
        chk("run_until_reached", ncen, target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{ADDR_FINE,   8'hA5, 8'hA5, 1'b0};
        tv[1] = '{ADDR_COARSE, 8'hC3, 8'hC3, 1'b0};
        tv[2] = '{ADDR_FINE,   8'h00, 8'h00, 1'b0};
        tv[3] = '{2'd3,        8'h77, 8'h00, 1'b0};
        tv[4] = '{ADDR_COARSE, 8'h00, 8'h00, 1'b1};
        tv[5] = '{ADDR_SHAPE,  8'h0B, 8'h0B, 1'b1};
        tv[6] = '{ADDR_FINE,   8'h01, 8'h01, 1'b0};
        tv[7] = '{ADDR_FINE,   8'h00, 8'h00, 1'b1};

        // Reset and idle
        repeat (3) cyc(1'b1, 1'b0, 2'd0, 8'd0);
        chk("rst_null", null_period, 1);
        chk("rst_step", step, 0);
        chk("rst_restart", restart, 0);
        chk("rst_ctrl", ctrl, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) cyc(1'b1, 1'b0, 2'd0, 8'd0);
        chk("idle_null", null_period, 1);
        chk("idle_step", step, 0);
        chk("idle_restart", restart, 0);
        chk("idle_ctrl", ctrl, 0);
        for (int a = 0; a < 4; a++) begin
            @(negedge clk) addr = 2'(a);
            #1 chk("idle_dout", dout, 0);
        end

        // Register table, cen idle
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, tv[i].addr, tv[i].din);
            cyc(1'b0, 1'b0, tv[i].addr, 8'd0);
            chk("tbl_dout", dout, tv[i].exp_dout);
            chk("tbl_null", null_period, tv[i].exp_null);
        end
        chk("tbl_ctrl", ctrl, 4'hB);
        chk("tbl_restart", restart, 1);

        // Period 3, cen every clk: steps 6 cen apart
        cyc(1'b1, 1'b1, ADDR_COARSE, 8'd0);
        cyc(1'b1, 1'b1, ADDR_FINE, 8'd3);
        chk("p3_null_same_edge", null_period, 1);
        cyc(1'b1, 1'b0, 2'd0, 8'd0);
        chk("p3_null_fell", null_period, 0);
        base = ncen;
        sb.push_back(base + 7);
        sb.push_back(base + 13);
        sb.push_back(base + 19);
        run_until(base + 21);
        chk("p3_sb_empty", sb.size(), 0);

        // Shape write between cens, cen every 4th clk
        cyc(1'b0, 1'b1, ADDR_SHAPE, 8'h0E);
        chk("shE_ctrl", ctrl, 4'hE);
        chk("shE_restart_set", restart, 1);
        repeat (3) begin
            cyc(1'b0, 1'b0, 2'd0, 8'd0);
            chk("shE_restart_hold", restart, 1);
        end
        cyc(1'b1, 1'b0, 2'd0, 8'd0);
        chk("shE_restart_clr", restart, 0);
        base = ncen;
        sb.push_back(base + 6);
        sb.push_back(base + 12);
        for (int i = 0; i < 100 && ncen < base + 14; i++) begin
            repeat (3) cyc(1'b0, 1'b0, 2'd0, 8'd0);
            cyc(1'b1, 1'b0, 2'd0, 8'd0);
        end
        chk("shE_cen_reached", ncen, base + 14);
        chk("shE_sb_empty", sb.size(), 0);

        // Period 100, shrink to 10 with cnt at 50
        cyc(1'b0, 1'b1, ADDR_FINE, 8'd100);
        cyc(1'b0, 1'b1, ADDR_SHAPE, 8'h0E);
        cyc(1'b1, 1'b0, 2'd0, 8'd0);
        chk("p100_restart_clr", restart, 0);
        base = ncen;
        run_until(base + 99);
        cyc(1'b1, 1'b1, ADDR_FINE, 8'd10);
        sb.push_back(base + 102);
        sb.push_back(base + 122);
        sb.push_back(base + 142);
        run_until(base + 144);
        chk("shrink_sb_empty", sb.size(), 0);

        // Shape write on a cen edge, second write before the next cen
        n_rst_samp = 0;
        cyc(1'b1, 1'b1, ADDR_SHAPE, 8'h05);
        chk("dbl_restart1", restart, 1);
        chk("dbl_ctrl1", ctrl, 4'h5);
        cyc(1'b0, 1'b0, 2'd0, 8'd0);
        cyc(1'b0, 1'b1, ADDR_SHAPE, 8'h09);
        chk("dbl_ctrl2", ctrl, 4'h9);
        chk("dbl_restart2", restart, 1);
        cyc(1'b0, 1'b0, 2'd0, 8'd0);
        cyc(1'b1, 1'b0, 2'd0, 8'd0);
        chk("dbl_restart_clr", restart, 0);
        chk("dbl_ctrl_final", ctrl, 4'h9);
        base = ncen;
        sb.push_back(base + 20);
        run_until(base + 20);
        chk("dbl_step_high", step, 1);
        chk("dbl_restart_samples", n_rst_samp, 1);
        chk("dbl_sb_empty", sb.size(), 0);

        // Async reset while step is high
        cen = 1'b0; wr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_step", step, 0);
        chk("arst_null", null_period, 1);
        chk("arst_restart", restart, 0);
        chk("arst_ctrl", ctrl, 0);
        for (int a = 0; a < 3; a++) begin
            addr = 2'(a);
            #1 chk("arst_dout", dout, 0);
        end
        step_prev = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Async reset while restart is pending
        cyc(1'b0, 1'b1, ADDR_FINE, 8'd3);
        cyc(1'b0, 1'b1, ADDR_SHAPE, 8'h06);
        chk("arst2_restart_set", restart, 1);
        chk("arst2_ctrl_set", ctrl, 4'h6);
        cyc(1'b0, 1'b0, ADDR_FINE, 8'd0);
        chk("arst2_null_pre", null_period, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst2_restart", restart, 0);
        chk("arst2_ctrl", ctrl, 0);
        chk("arst2_null", null_period, 1);
        chk("arst2_fine", dout, 0);
        @(negedge clk) rst_n = 1'b1;
        n_rst_samp = 0;
        repeat (4) cyc(1'b1, 1'b0, 2'd0, 8'd0);
        chk("arst2_no_restart_samples", n_rst_samp, 0);
        chk("arst2_restart_after", restart, 0);
        chk("arst2_null_after", null_period, 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
